// File: rtl/gelato_fetch_sched.sv
// Per-warp PC table with a round-robin fetch scheduler. Offers one warp's PC
// at a time on a valid/ready handshake and tracks one outstanding fetch per warp.
module gelato_fetch_sched #(
    parameter int NUM_WARPS = 4,
    parameter int PC_W      = 32,
    parameter int SPLIT_W   = 4,
    parameter int WARP_W    = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 launch_valid,
    input  logic [WARP_W-1:0]    launch_warp,
    input  logic [PC_W-1:0]      launch_pc,
    input  logic                 redirect_valid,
    input  logic [WARP_W-1:0]    redirect_warp,
    input  logic [PC_W-1:0]      redirect_pc,
    input  logic [SPLIT_W-1:0]   redirect_split,
    input  logic                 done_valid,
    input  logic [WARP_W-1:0]    done_warp,
    input  logic                 exit_valid,
    input  logic [WARP_W-1:0]    exit_warp,
    input  logic [NUM_WARPS-1:0] ibuf_full,
    output logic                 fetch_valid,
    input  logic                 fetch_ready,
    output logic [PC_W-1:0]      fetch_pc,
    output logic [WARP_W-1:0]    fetch_warp_num,
    output logic [SPLIT_W-1:0]   fetch_split_table_num
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;

    logic [0:0]                          state_reg;
    logic [WARP_W-1:0]                   rr_ptr_reg;
    logic [PC_W-1:0]                     fetch_pc_reg;
    logic [WARP_W-1:0]                   fetch_warp_reg;
    logic [SPLIT_W-1:0]                  fetch_split_reg;

    logic [NUM_WARPS-1:0]                active_all;
    logic [NUM_WARPS-1:0]                pending_all;
    logic [NUM_WARPS-1:0][PC_W-1:0]      pc_all;
    logic [NUM_WARPS-1:0][SPLIT_W-1:0]   split_all;
    logic [NUM_WARPS-1:0]                eligible;

    logic                                accept;
    logic                                sel_found;
    logic [WARP_W-1:0]                   sel_idx;

    assign accept   = (state_reg == OFFER) && fetch_ready;
    assign eligible = active_all & ~pending_all & ~ibuf_full;

    // First eligible warp at or above rr_ptr, wrapping around the warp count.
    always_comb begin
        logic [WARP_W-1:0] cand;
        cand      = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            cand = rr_ptr_reg + WARP_W'(i);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
        localparam logic [WARP_W-1:0] WID = WARP_W'(gi);

        logic              active_reg, active_next;
        logic              pending_reg, pending_next;
        logic [PC_W-1:0]   pc_reg, pc_next;
        logic [SPLIT_W-1:0] split_reg, split_next;

        logic launch_hit, redirect_hit, done_hit, exit_hit, accept_hit;

        assign launch_hit   = launch_valid && (launch_warp == WID);
        assign redirect_hit = redirect_valid && (redirect_warp == WID) && active_reg;
        assign done_hit     = done_valid && (done_warp == WID);
        assign exit_hit     = exit_valid && (exit_warp == WID);
        assign accept_hit   = accept && (fetch_warp_reg == WID);

        // Exit dominates everything; launch dominates the remaining events.
        always_comb begin
            active_next  = active_reg;
            pending_next = pending_reg;
            pc_next      = pc_reg;
            split_next   = split_reg;
            if (exit_hit) begin
                active_next  = 1'b0;
                pending_next = 1'b0;
            end else if (launch_hit) begin
                active_next  = 1'b1;
                pending_next = 1'b0;
                pc_next      = launch_pc;
                split_next   = '0;
            end else begin
                if (redirect_hit) begin
                    pc_next    = redirect_pc;
                    split_next = redirect_split;
                end else if (accept_hit) begin
                    pc_next = pc_reg + PC_W'(4);
                end
                if (done_hit) begin
                    pending_next = 1'b0;
                end else if (accept_hit) begin
                    pending_next = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                active_reg  <= 1'b0;
                pending_reg <= 1'b0;
                pc_reg      <= '0;
                split_reg   <= '0;
            end else if (rdy) begin
                active_reg  <= active_next;
                pending_reg <= pending_next;
                pc_reg      <= pc_next;
                split_reg   <= split_next;
            end
        end

        assign active_all[gi]  = active_reg;
        assign pending_all[gi] = pending_reg;
        assign pc_all[gi]      = pc_reg;
        assign split_all[gi]   = split_reg;
    end

    // Once raised, an offer is held unchanged until the fetch unit takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            fetch_pc_reg    <= '0;
            fetch_warp_reg  <= '0;
            fetch_split_reg <= '0;
        end else if (rdy) begin
            case (state_reg)
                IDLE: begin
                    if (sel_found) begin
                        state_reg       <= OFFER;
                        fetch_pc_reg    <= pc_all[sel_idx];
                        fetch_warp_reg  <= sel_idx;
                        fetch_split_reg <= split_all[sel_idx];
                    end
                end
                default: begin
                    if (fetch_ready) begin
                        state_reg  <= IDLE;
                        rr_ptr_reg <= fetch_warp_reg + WARP_W'(1);
                    end
                end
            endcase
        end
    end

    assign fetch_valid           = (state_reg == OFFER);
    assign fetch_pc              = fetch_pc_reg;
    assign fetch_warp_num        = fetch_warp_reg;
    assign fetch_split_table_num = fetch_split_reg;

endmodule
